// File: rtl/note_sprite_drawer_if.sv
// Placement-write channel of note_sprite_drawer: the placing agent is master, the drawer is slave.
interface note_sprite_drawer_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic              wr_valid;
  logic              wr_ready;
  logic [SLOT_W-1:0] wr_slot;
  logic              wr_en;
  logic [9:0]        wr_x;
  logic [9:0]        wr_y;

  modport master (
    output wr_valid, wr_slot, wr_en, wr_x, wr_y,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_slot, wr_en, wr_x, wr_y,
    output wr_ready
  );
endinterface

// File: rtl/note_sprite_drawer.sv
// Draws up to NUM_SLOTS note sprites: double-buffered placement tables swapped in vblank,
// per-pixel hit test with lowest-slot priority, sprite ROM lookup, fixed 3-cycle latency.
module note_sprite_drawer #(
  parameter int NUM_SLOTS = 8,
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         px_valid,
  input  logic [9:0]                   px_x,
  input  logic [9:0]                   px_y,
  note_sprite_drawer_if.slave          wr,
  output logic [9:0]                   rom_addr,
  input  logic                         rom_pixel,
  output logic                         out_valid,
  output logic                         out_on,
  output logic [$clog2(NUM_SLOTS)-1:0] out_slot
);

  localparam int                SLOT_W    = $clog2(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [10:0]       SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]       SPR_H11   = 11'(SPR_H);
  localparam logic [9:0]        SPR_W10   = 10'(SPR_W);

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } place_t;

  typedef enum logic {
    IDLE,
    COMMIT
  } state_t;

  place_t            shadow_tab [NUM_SLOTS];
  place_t            active_tab [NUM_SLOTS];
  state_t            state;
  logic [SLOT_W-1:0] commit_idx;

  // Writes are only taken while the active table is not being copied into.
  assign wr.wr_ready = (state == IDLE);

  // ---------------------------------------------------------------------------
  // Placement tables and commit FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every read in
  // this block sees the value from before the clock edge (the commit copy relies
  // on that when a write lands in the frame_start cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      commit_idx <= '0;
      // NOTE: the tables are small flop arrays, not RAM, so they are cleared in
      // reset; an aborted commit must leave every slot disabled.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_tab[i] <= '0;
        active_tab[i] <= '0;
      end
    end else begin
      if (wr.wr_valid && wr.wr_ready) begin
        shadow_tab[wr.wr_slot] <= '{en: wr.wr_en, x: wr.wr_x, y: wr.wr_y};
      end

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= COMMIT;
            commit_idx <= '0;
          end
        end
        COMMIT: begin
          active_tab[commit_idx] <= shadow_tab[commit_idx];
          commit_idx             <= commit_idx + SLOT_W'(1);
          if (commit_idx == LAST_SLOT) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Hit test against the active table (11-bit sums so x+SPR_W never wraps)
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] in_box;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    in_box = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      in_box[i] = px_valid && active_tab[i].en
               && ({1'b0, px_x} >= {1'b0, active_tab[i].x})
               && ({1'b0, px_x} <  ({1'b0, active_tab[i].x} + SPR_W11))
               && ({1'b0, px_y} >= {1'b0, active_tab[i].y})
               && ({1'b0, px_y} <  ({1'b0, active_tab[i].y} + SPR_H11));
    end
  end

  logic              hit;
  logic [SLOT_W-1:0] hit_slot;
  logic [9:0]        off_x;
  logic [9:0]        off_y;
  logic [9:0]        addr_c;

  // Scanning from the top slot down lets the lowest-index hit be the last writer.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    off_x    = '0;
    off_y    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (in_box[i]) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(i);
        off_x    = px_x - active_tab[i].x;
        off_y    = px_y - active_tab[i].y;
      end
    end
  end

  // Offsets are zero on a miss, so the address falls to 0 without a mux.
  assign addr_c = off_y * SPR_W10 + off_x;

  // ---------------------------------------------------------------------------
  // Pixel pipeline: stage 1 issues the ROM address, stage 2 waits for ROM data
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic              s1_hit;
  logic [SLOT_W-1:0] s1_slot;
  logic              s2_valid;
  logic              s2_hit;
  logic [SLOT_W-1:0] s2_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_slot   <= '0;
      s2_valid  <= 1'b0;
      s2_hit    <= 1'b0;
      s2_slot   <= '0;
      out_valid <= 1'b0;
      out_on    <= 1'b0;
      out_slot  <= '0;
    end else begin
      rom_addr  <= addr_c;
      s1_valid  <= px_valid;
      s1_hit    <= hit;
      s1_slot   <= hit_slot;
      s2_valid  <= s1_valid;
      s2_hit    <= s1_hit;
      s2_slot   <= s1_slot;
      out_valid <= s2_valid;
      out_on    <= s2_hit && rom_pixel;
      out_slot  <= s2_slot;
    end
  end

endmodule

// File: doc/note_sprite_drawer.md
NOTE_SPRITE_DRAWER -- requirements
Module: note_sprite_drawer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, number of independently placed note sprites.
REQ-002 SHALL have parameter SPR_W, default 20, sprite width in pixels.
REQ-003 SHALL have parameter SPR_H, default 30, sprite height in pixels (SPR_W*SPR_H <= 1024).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-007 SHALL have port px_valid  input  1  current pixel is in active video.
REQ-008 SHALL have port px_x  input  10  current pixel column.
REQ-009 SHALL have port px_y  input  10  current pixel row.
REQ-010 SHALL have port wr_valid  input  1  placement write request.
REQ-011 SHALL have port wr_ready  output  1  placement write can be accepted.
REQ-012 SHALL have port wr_slot  input  $clog2(NUM_SLOTS)  slot being written.
REQ-013 SHALL have port wr_en  input  1  slot enable value.
REQ-014 SHALL have port wr_x  input  10  sprite top-left column.
REQ-015 SHALL have port wr_y  input  10  sprite top-left row.
REQ-016 SHALL have port rom_addr  output  10  address to sprite ROM (row*SPR_W+col).
REQ-017 SHALL have port rom_pixel  input  1  ROM data, valid one cycle after rom_addr.
REQ-018 SHALL have port out_valid  output  1  delayed px_valid.
REQ-019 SHALL have port out_on  output  1  sprite pixel lit at this position.
REQ-020 SHALL have port out_slot  output  $clog2(NUM_SLOTS)  slot that produced the hit.

Function
REQ-021 SHALL hold two placement tables, shadow and active, each NUM_SLOTS entries of {en, x, y}.
REQ-022 SHALL write shadow[wr_slot] in any cycle with wr_valid && wr_ready; active unaffected.
REQ-023 SHALL run FSM IDLE/COMMIT: IDLE->COMMIT on frame_start; in COMMIT copy shadow[i] to active[i], i = 0..NUM_SLOTS-1, one slot per cycle; COMMIT->IDLE after slot NUM_SLOTS-1.
REQ-024 SHALL drive wr_ready = 1 only in IDLE (registered state; includes frame_start cycle).
REQ-025 SHALL commit a write accepted in the frame_start cycle in that same commit.
REQ-026 SHALL ignore frame_start while in COMMIT.
REQ-027 SHALL compute hit for slot i when active.en && px_x >= x && px_x < x+SPR_W && px_y >= y && px_y < y+SPR_H, sums in 11 bits (no wrap near 1023).
REQ-028 SHALL select the lowest-index hitting slot when sprites overlap.
REQ-029 SHALL use px_x/px_y only when px_valid = 1; px_valid = 0 forces miss.
REQ-030 SHALL register, at cycle t+1 for pixel at t: rom_addr = (px_y-y)*SPR_W + (px_x-x) on hit, 0 on miss; plus hit, slot and px_valid pipeline bits.
REQ-031 SHALL register at t+3: out_valid = px_valid(t), out_on = hit(t) && rom_pixel, out_slot = winning slot (0 on miss); fixed latency 3.
REQ-032 SHALL accept a new pixel every cycle with no stalls.
REQ-033 SHALL use active table during COMMIT; slots not yet copied keep previous values.

Reset
REQ-034 SHALL, on reset, clear all shadow and active entries to en=0, x=0, y=0, FSM to IDLE, rom_addr/out_valid/out_on/out_slot and pipeline bits to 0.
REQ-035 SHALL abort a commit in progress on reset; wr_ready = 1 the cycle after reset deasserts.

Verification
REQ-036 Write slot0 {en=1,x=100,y=50}, pulse frame_start, wait 9 cycles, drive px(100,50) -> rom_addr=0 at t+1, out_on=rom_pixel, out_slot=0 at t+3.
REQ-037 Same placement, px(119,79) -> rom_addr=599; px(120,79) and px(119,80) -> rom_addr=0, out_on=0.
REQ-038 Slot2 {x=10,y=10}, slot5 {x=15,y=10}, both enabled, px(16,12) -> out_slot=2, rom_addr=46.
REQ-039 Write slot1 without frame_start, scan its area -> out_on=0; after frame_start+commit -> lit; wr_ready=0 exactly 8 cycles after frame_start cycle.
REQ-040 Slot0 {x=1015,y=1000}, px(1023,1010) -> hit, rom_addr=208; px(0,1010) -> miss.
REQ-041 Assert reset on 3rd COMMIT cycle -> all outputs 0, active all disabled, wr_ready=1 after release.
